// File: rtl/led_shift_ctrl_if.sv
// rtl/led_shift_ctrl_if.sv - switch/button inputs and LED shift-register strobes of led_shift_ctrl
interface led_shift_ctrl_if;
   logic [3:0] i_sw;
   logic       i_btn_step;
   logic       o_valid;
   logic       o_sr_reset;
   logic [1:0] o_state;

   modport master (
      input  i_sw,
      input  i_btn_step,
      output o_valid,
      output o_sr_reset,
      output o_state
   );

   modport slave (
      output i_sw,
      output i_btn_step,
      input  o_valid,
      input  o_sr_reset,
      input  o_state
   );
endinterface

// File: rtl/led_shift_ctrl.sv
// rtl/led_shift_ctrl.sv - paces an external LED shift register: run/pause/step/clear from switches and a debounced button
module led_shift_ctrl #(
   parameter int NB_CNT    = 32,
   parameter int LIMIT_0   = 2**20,
   parameter int LIMIT_1   = 2**21,
   parameter int LIMIT_2   = 2**22,
   parameter int LIMIT_3   = 2**23,
   parameter int DEB_LIMIT = 50000
) (
   input  logic              clock,
   input  logic              i_reset,
   led_shift_ctrl_if.master  bus
);

   typedef enum logic [1:0] {
      ST_INIT  = 2'b00,
      ST_PAUSE = 2'b01,
      ST_RUN   = 2'b10
   } state_t;

   localparam int DEB_W = $clog2(DEB_LIMIT);
   localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_LIMIT - 1);
   localparam logic [NB_CNT-1:0] LAST_0   = NB_CNT'(LIMIT_0 - 1);
   localparam logic [NB_CNT-1:0] LAST_1   = NB_CNT'(LIMIT_1 - 1);
   localparam logic [NB_CNT-1:0] LAST_2   = NB_CNT'(LIMIT_2 - 1);
   localparam logic [NB_CNT-1:0] LAST_3   = NB_CNT'(LIMIT_3 - 1);

   logic [3:0]        sw_meta, sw_sync;
   logic              btn_meta, btn_sync;
   logic [DEB_W-1:0]  deb_cnt;
   logic              btn_stable, btn_stable_q;
   logic              step_req;
   logic [NB_CNT-1:0] rate_cnt;
   logic [NB_CNT-1:0] rate_last;
   logic              terminal;
   state_t            state, state_next;
   logic              valid_int, sr_reset_int;

   always_ff @(posedge clock) begin
      if (i_reset) begin
         sw_meta  <= '0;
         sw_sync  <= '0;
         btn_meta <= 1'b0;
         btn_sync <= 1'b0;
      end else begin
         sw_meta  <= bus.i_sw;
         sw_sync  <= sw_meta;
         btn_meta <= bus.i_btn_step;
         btn_sync <= btn_meta;
      end
   end

   // The stable value only follows the synced button after DEB_LIMIT consecutive differing cycles.
   always_ff @(posedge clock) begin
      if (i_reset) begin
         deb_cnt      <= '0;
         btn_stable   <= 1'b0;
         btn_stable_q <= 1'b0;
      end else begin
         btn_stable_q <= btn_stable;
         if (btn_sync == btn_stable) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_LAST) begin
            btn_stable <= btn_sync;
            deb_cnt    <= '0;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end
      end
   end

   assign step_req = btn_stable & ~btn_stable_q;

   always_comb begin
      rate_last = LAST_0;
      case (sw_sync[2:1])
         2'd0:    rate_last = LAST_0;
         2'd1:    rate_last = LAST_1;
         2'd2:    rate_last = LAST_2;
         default: rate_last = LAST_3;
      endcase
   end

   // >= rather than == so a drop to a faster speed fires at once instead of wrapping.
   assign terminal = (rate_cnt >= rate_last);

   always_ff @(posedge clock) begin
      if (i_reset) begin
         state <= ST_INIT;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = ST_INIT;
      case (state)
         ST_INIT:  state_next = ST_PAUSE;
         ST_PAUSE: state_next = sw_sync[3] ? ST_INIT :
                                sw_sync[0] ? ST_RUN  : ST_PAUSE;
         ST_RUN:   state_next = sw_sync[3] ? ST_INIT :
                                sw_sync[0] ? ST_RUN  : ST_PAUSE;
         default:  state_next = ST_INIT;
      endcase
   end

   always_ff @(posedge clock) begin
      if (i_reset) begin
         rate_cnt <= '0;
      end else if (state == ST_RUN && state_next == ST_RUN) begin
         rate_cnt <= terminal ? '0 : rate_cnt + 1'b1;
      end else begin
         rate_cnt <= '0;
      end
   end

   always_comb begin
      valid_int    = 1'b0;
      sr_reset_int = 1'b0;
      case (state)
         ST_INIT:  sr_reset_int = 1'b1;
         ST_PAUSE: valid_int    = step_req;
         ST_RUN:   valid_int    = terminal;
         default:  ;
      endcase
   end

   // Reset masks the strobes in the very cycle it is raised, so a period in flight never fires.
   assign bus.o_valid    = valid_int & ~i_reset;
   assign bus.o_sr_reset = sr_reset_int & ~i_reset;
   assign bus.o_state    = i_reset ? ST_INIT : state;

endmodule
